line_sched: RTL and testbench
=============================

# line_sched

Frame-level line scheduler for the buffer-read line controller. It accepts one frame descriptor: per-lane start addresses, line stride, line count, line length and pad/FIFO flags. It then issues one line command per line to the line controller, and never while that controller is busy, because a new command would truncate the line in progress. It reports completion once the last line has drained.

## Interface
Parameters:
- X_MAC, 4, number of address lanes (one start address per MAC column)
- ADDR_LEN, 13, buffer address width per lane
- MAX_LINE_LEN, 10, width of line length field
- LINE_CNT_LEN, 10, width of line count field

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- cfg_valid  in  1  descriptor present
- cfg_ready  out  1  high only in IDLE; descriptor accepted on cfg_valid & cfg_ready
- cfg_base  in  ADDR_LEN*X_MAC  lane j start address at bits [j*ADDR_LEN +: ADDR_LEN]
- cfg_stride  in  ADDR_LEN  address increment per line, added to every lane
- cfg_lines  in  LINE_CNT_LEN  number of lines; 0 is legal
- cfg_linelen  in  MAX_LINE_LEN  line length, forwarded unchanged
- cfg_ispad, cfg_tofifo, cfg_fromfifo  in  1 each  forwarded on every line
- abort  in  1  synchronous frame cancel
- lc_valid  out  1  one-cycle line command strobe
- lc_st_addr  out  ADDR_LEN*X_MAC  line start addresses
- lc_linelen  out  MAX_LINE_LEN  line length
- lc_ispad, lc_tofifo, lc_fromfifo  out  1 each  line flags
- lc_busy  in  1  line controller working flag
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at normal frame end
- lines_issued  out  LINE_CNT_LEN  commands issued in the current frame

## Operation
- Acceptance copies all cfg_* fields into registers. cur_addr = cfg_base. remaining = cfg_lines. lines_issued = 0.
- States: IDLE, ISSUE, WAIT_START, WAIT_END, DONE.
- IDLE: cfg_ready = 1. On acceptance, go to DONE if cfg_lines == 0, otherwise go to ISSUE.
- ISSUE: if lc_busy == 0, do all of the following at the clock edge, then go to WAIT_START:
  - register lc_valid = 1;
  - set lc_st_addr = cur_addr, plus linelen and flags;
  - set cur_addr[j] += stride for every lane j, mod 2^ADDR_LEN, carries not propagated between lanes;
  - decrement remaining and increment lines_issued.
  If lc_busy == 1, hold.
- WAIT_START: wait for lc_busy == 1, then go to WAIT_END. Guards against sampling the stale low busy in the cycle right after the strobe.
- WAIT_END: wait for lc_busy == 0. Then go to DONE if remaining == 0, otherwise go to ISSUE.
- DONE: done = 1 for exactly this cycle, then go to IDLE.
- abort, from any non-IDLE state: next state is IDLE. No done pulse. lc_valid is forced low that cycle. lines_issued holds its value until the next acceptance.
- lc_st_addr, lc_linelen and the lc flags hold their last issued values between strobes. They are meaningful only when lc_valid = 1.
- Reset values: state IDLE; lc_valid 0; lc_st_addr 0; lc_linelen 0; lc_ispad, lc_tofifo, lc_fromfifo 0; done 0; busy 0; lines_issued 0; cfg_ready 1 (combinational from IDLE).
- Reset mid-frame discards the frame immediately. No command or done is emitted afterwards.

## Timing
- All outputs are registered except cfg_ready and busy, which decode directly from the state.
- Acceptance at edge T puts the block in ISSUE during cycle T..T+1. With lc_busy low, lc_valid is high during T+1..T+2. The first command therefore appears one cycle after acceptance.
- Minimum gap between consecutive lc_valid strobes: line-controller busy duration + 3 cycles (WAIT_START, WAIT_END exit, ISSUE).
- done is asserted 2 cycles after the final lc_busy fall (WAIT_END to DONE, then DONE registered). For cfg_lines = 0, done is high in the second cycle after acceptance.
- A cfg_valid during the DONE cycle is not accepted. It can be accepted in the next IDLE cycle.
- abort and a same-cycle lc_busy change: abort wins.

## Test plan
- Three-line frame: base lanes {0,100,200,300}, stride 16, lines 3, linelen 8, ispad 1. Emulated controller is busy 3 cycles per line. Required response:
  - exactly 3 lc_valid strobes;
  - lane addresses {0,100,200,300}, then {16,116,216,316}, then {32,132,232,332};
  - linelen 8 and ispad 1 on each strobe;
  - one done pulse; lines_issued = 3.
- Zero lines: cfg_lines 0 -> no lc_valid, done high 2 cycles after acceptance, cfg_ready high again on the next cycle.
- Busy stall: hold lc_busy high for 20 cycles before acceptance -> no lc_valid until lc_busy falls, then the strobe appears on the next cycle.
- Wrap: ADDR_LEN 13, lane0 base 8190, stride 4, lines 2 -> second lane0 address is 2, and the other lanes are unaffected.
- Abort after the second of 4 lines -> IDLE on the next cycle, no further lc_valid, no done, lines_issued = 2.
- Asynchronous rst pulse mid-WAIT_END -> all outputs at reset values immediately. A new frame accepted after reset runs correctly from its own base address.

Source files
------------

// File: rtl/line_sched.sv
// Frame-level line scheduler: takes one frame descriptor and issues one line
// command per line to the line controller, never while that controller is busy.
module line_sched #(
  parameter int X_MAC        = 4,
  parameter int ADDR_LEN     = 13,
  parameter int MAX_LINE_LEN = 10,
  parameter int LINE_CNT_LEN = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cfg_valid,
  output logic                         cfg_ready,
  input  logic [ADDR_LEN*X_MAC-1:0]    cfg_base,
  input  logic [ADDR_LEN-1:0]          cfg_stride,
  input  logic [LINE_CNT_LEN-1:0]      cfg_lines,
  input  logic [MAX_LINE_LEN-1:0]      cfg_linelen,
  input  logic                         cfg_ispad,
  input  logic                         cfg_tofifo,
  input  logic                         cfg_fromfifo,
  input  logic                         abort,
  output logic                         lc_valid,
  output logic [ADDR_LEN*X_MAC-1:0]    lc_st_addr,
  output logic [MAX_LINE_LEN-1:0]      lc_linelen,
  output logic                         lc_ispad,
  output logic                         lc_tofifo,
  output logic                         lc_fromfifo,
  input  logic                         lc_busy,
  output logic                         busy,
  output logic                         done,
  output logic [LINE_CNT_LEN-1:0]      lines_issued
);

  localparam int AW = ADDR_LEN * X_MAC;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_ISSUE      = 3'd1;
  localparam logic [2:0] S_WAIT_START = 3'd2;
  localparam logic [2:0] S_WAIT_END   = 3'd3;
  localparam logic [2:0] S_DONE       = 3'd4;

  localparam logic [LINE_CNT_LEN-1:0] ONE_LINE = LINE_CNT_LEN'(1);

  logic [2:0]              state_q, state_d;
  logic [AW-1:0]           cur_addr_q, cur_addr_d, next_addr;
  logic [ADDR_LEN-1:0]     stride_q, stride_d;
  logic [LINE_CNT_LEN-1:0] remaining_q, remaining_d;
  logic [LINE_CNT_LEN-1:0] lines_issued_q, lines_issued_d;
  logic [MAX_LINE_LEN-1:0] linelen_q, linelen_d;
  logic                    ispad_q, ispad_d;
  logic                    tofifo_q, tofifo_d;
  logic                    fromfifo_q, fromfifo_d;

  logic                    lc_valid_q, lc_valid_d;
  logic [AW-1:0]           lc_st_addr_q, lc_st_addr_d;
  logic [MAX_LINE_LEN-1:0] lc_linelen_q, lc_linelen_d;
  logic                    lc_ispad_q, lc_ispad_d;
  logic                    lc_tofifo_q, lc_tofifo_d;
  logic                    lc_fromfifo_q, lc_fromfifo_d;
  logic                    done_q, done_d;

  // Each lane advances independently; a lane's carry must never spill into its neighbour.
  always_comb begin
    next_addr = '0;
    for (int j = 0; j < X_MAC; j++) begin
      next_addr[j*ADDR_LEN +: ADDR_LEN] = cur_addr_q[j*ADDR_LEN +: ADDR_LEN] + stride_q;
    end
  end

  always_comb begin
    state_d        = state_q;
    cur_addr_d     = cur_addr_q;
    stride_d       = stride_q;
    remaining_d    = remaining_q;
    lines_issued_d = lines_issued_q;
    linelen_d      = linelen_q;
    ispad_d        = ispad_q;
    tofifo_d       = tofifo_q;
    fromfifo_d     = fromfifo_q;
    lc_valid_d     = 1'b0;
    lc_st_addr_d   = lc_st_addr_q;
    lc_linelen_d   = lc_linelen_q;
    lc_ispad_d     = lc_ispad_q;
    lc_tofifo_d    = lc_tofifo_q;
    lc_fromfifo_d  = lc_fromfifo_q;
    done_d         = 1'b0;

    // Abort overrides everything, including an issue that would otherwise fire this edge.
    if (abort && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            cur_addr_d     = cfg_base;
            stride_d       = cfg_stride;
            remaining_d    = cfg_lines;
            lines_issued_d = '0;
            linelen_d      = cfg_linelen;
            ispad_d        = cfg_ispad;
            tofifo_d       = cfg_tofifo;
            fromfifo_d     = cfg_fromfifo;
            state_d        = (cfg_lines == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!lc_busy) begin
            lc_valid_d     = 1'b1;
            lc_st_addr_d   = cur_addr_q;
            lc_linelen_d   = linelen_q;
            lc_ispad_d     = ispad_q;
            lc_tofifo_d    = tofifo_q;
            lc_fromfifo_d  = fromfifo_q;
            cur_addr_d     = next_addr;
            remaining_d    = remaining_q - ONE_LINE;
            lines_issued_d = lines_issued_q + ONE_LINE;
            state_d        = S_WAIT_START;
          end
        end
        S_WAIT_START: begin
          if (lc_busy) begin
            state_d = S_WAIT_END;
          end
        end
        S_WAIT_END: begin
          if (!lc_busy) begin
            state_d = (remaining_q == '0) ? S_DONE : S_ISSUE;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cur_addr_q     <= '0;
      stride_q       <= '0;
      remaining_q    <= '0;
      lines_issued_q <= '0;
      linelen_q      <= '0;
      ispad_q        <= 1'b0;
      tofifo_q       <= 1'b0;
      fromfifo_q     <= 1'b0;
      lc_valid_q     <= 1'b0;
      lc_st_addr_q   <= '0;
      lc_linelen_q   <= '0;
      lc_ispad_q     <= 1'b0;
      lc_tofifo_q    <= 1'b0;
      lc_fromfifo_q  <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_addr_q     <= cur_addr_d;
      stride_q       <= stride_d;
      remaining_q    <= remaining_d;
      lines_issued_q <= lines_issued_d;
      linelen_q      <= linelen_d;
      ispad_q        <= ispad_d;
      tofifo_q       <= tofifo_d;
      fromfifo_q     <= fromfifo_d;
      lc_valid_q     <= lc_valid_d;
      lc_st_addr_q   <= lc_st_addr_d;
      lc_linelen_q   <= lc_linelen_d;
      lc_ispad_q     <= lc_ispad_d;
      lc_tofifo_q    <= lc_tofifo_d;
      lc_fromfifo_q  <= lc_fromfifo_d;
      done_q         <= done_d;
    end
  end

  assign cfg_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign lc_valid     = lc_valid_q;
  assign lc_st_addr   = lc_st_addr_q;
  assign lc_linelen   = lc_linelen_q;
  assign lc_ispad     = lc_ispad_q;
  assign lc_tofifo    = lc_tofifo_q;
  assign lc_fromfifo  = lc_fromfifo_q;
  assign done         = done_q;
  assign lines_issued = lines_issued_q;

endmodule

// File: tb/tb_line_sched.sv
// Directed testbench for line_sched with an emulated line controller that stays
// busy for three cycles after every line command.
module tb_line_sched;

  localparam int X_MAC        = 4;
  localparam int ADDR_LEN     = 13;
  localparam int MAX_LINE_LEN = 10;
  localparam int LINE_CNT_LEN = 10;
  localparam int AW           = ADDR_LEN * X_MAC;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [AW-1:0]           cfg_base;
  logic [ADDR_LEN-1:0]     cfg_stride;
  logic [LINE_CNT_LEN-1:0] cfg_lines;
  logic [MAX_LINE_LEN-1:0] cfg_linelen;
  logic                    cfg_ispad;
  logic                    cfg_tofifo;
  logic                    cfg_fromfifo;
  logic                    abort;
  logic                    lc_valid;
  logic [AW-1:0]           lc_st_addr;
  logic [MAX_LINE_LEN-1:0] lc_linelen;
  logic                    lc_ispad;
  logic                    lc_tofifo;
  logic                    lc_fromfifo;
  logic                    lc_busy;
  logic                    busy;
  logic                    done;
  logic [LINE_CNT_LEN-1:0] lines_issued;

  int checkCount = 0;
  int passCount  = 0;

  line_sched #(
    .X_MAC(X_MAC), .ADDR_LEN(ADDR_LEN), .MAX_LINE_LEN(MAX_LINE_LEN), .LINE_CNT_LEN(LINE_CNT_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_base(cfg_base), .cfg_stride(cfg_stride),
    .cfg_lines(cfg_lines), .cfg_linelen(cfg_linelen), .cfg_ispad(cfg_ispad),
    .cfg_tofifo(cfg_tofifo), .cfg_fromfifo(cfg_fromfifo), .abort(abort),
    .lc_valid(lc_valid), .lc_st_addr(lc_st_addr), .lc_linelen(lc_linelen),
    .lc_ispad(lc_ispad), .lc_tofifo(lc_tofifo), .lc_fromfifo(lc_fromfifo),
    .lc_busy(lc_busy), .busy(busy), .done(done), .lines_issued(lines_issued)
  );

  always #5 clk = ~clk;

  // Emulated line controller: busy for three cycles per command, plus a manual override.
  int   busyCnt   = 0;
  logic forceBusy = 1'b0;
  assign lc_busy = forceBusy || (busyCnt != 0);

  always @(negedge clk) begin
    if (lc_valid) busyCnt = 3;
    else if (busyCnt > 0) busyCnt = busyCnt - 1;
  end

  // Monitor logs every strobe and counts done pulses.
  int                      strobeCount = 0;
  int                      doneCount   = 0;
  logic [AW-1:0]           addrLog [64];
  logic [MAX_LINE_LEN-1:0] lenLog  [64];
  logic                    padLog  [64];

  always @(negedge clk) begin
    if (lc_valid) begin
      if (strobeCount < 64) begin
        addrLog[strobeCount] = lc_st_addr;
        lenLog[strobeCount]  = lc_linelen;
        padLog[strobeCount]  = lc_ispad;
      end
      strobeCount = strobeCount + 1;
    end
    if (done) doneCount = doneCount + 1;
  end

  function automatic logic [ADDR_LEN-1:0] laneOf(input logic [AW-1:0] v, input int j);
    return v[j*ADDR_LEN +: ADDR_LEN];
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount = checkCount + 1;
    if (observed === expected) passCount = passCount + 1;
    else $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [AW-1:0] base, input logic [ADDR_LEN-1:0] stride,
                               input logic [LINE_CNT_LEN-1:0] lines, input logic [MAX_LINE_LEN-1:0] len,
                               input logic pad, input logic tof, input logic fromf);
    @(negedge clk);
    cfg_base     = base;
    cfg_stride   = stride;
    cfg_lines    = lines;
    cfg_linelen  = len;
    cfg_ispad    = pad;
    cfg_tofifo   = tof;
    cfg_fromfifo = fromf;
    cfg_valid    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cfg_valid    = 1'b0;
  endtask

  task automatic waitFrameEnd(input int maxCycles, input string tag);
    for (int i = 0; i < maxCycles; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checkOutput({tag, "_frame_end"}, busy, 0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int sBase, dBase, seen;
    rst = 1'b1; cfg_valid = 1'b0; abort = 1'b0;
    cfg_base = '0; cfg_stride = '0; cfg_lines = '0; cfg_linelen = '0;
    cfg_ispad = 1'b0; cfg_tofifo = 1'b0; cfg_fromfifo = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_cfg_ready", cfg_ready, 1);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_lc_valid", lc_valid, 0);
    checkOutput("rst_lines_issued", lines_issued, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] three-line frame");
    sBase = strobeCount; dBase = doneCount;
    applyStimulus({13'd300, 13'd200, 13'd100, 13'd0}, 13'd16, 10'd3, 10'd8, 1'b1, 1'b0, 1'b0);
    waitFrameEnd(200, "three");
    checkOutput("three_strobes", strobeCount - sBase, 3);
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < X_MAC; j++)
        checkOutput($sformatf("three_addr_l%0d_lane%0d", i, j), laneOf(addrLog[sBase+i], j), 100*j + 16*i);
      checkOutput($sformatf("three_len_l%0d", i), lenLog[sBase+i], 8);
      checkOutput($sformatf("three_pad_l%0d", i), padLog[sBase+i], 1);
    end
    checkOutput("three_done", doneCount - dBase, 1);
    checkOutput("three_lines_issued", lines_issued, 3);

    $display("[TB] zero-line frame");
    sBase = strobeCount; dBase = doneCount;
    applyStimulus({13'd4, 13'd3, 13'd2, 13'd1}, 13'd1, 10'd0, 10'd1, 1'b0, 1'b0, 1'b0);
    checkOutput("zero_done_c1", done, 0);
    checkOutput("zero_ready_c1", cfg_ready, 0);
    @(negedge clk);
    checkOutput("zero_done_c2", done, 1);
    checkOutput("zero_ready_c2", cfg_ready, 1);
    @(negedge clk);
    #1;
    checkOutput("zero_done_c3", done, 0);
    checkOutput("zero_strobes", strobeCount - sBase, 0);
    checkOutput("zero_done_count", doneCount - dBase, 1);
    checkOutput("zero_lines_issued", lines_issued, 0);

    $display("[TB] busy stall");
    sBase = strobeCount; dBase = doneCount;
    forceBusy = 1'b1;
    applyStimulus({13'd40, 13'd30, 13'd20, 13'd10}, 13'd0, 10'd1, 10'd2, 1'b0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("stall_no_strobe", strobeCount - sBase, 0);
    checkOutput("stall_busy", busy, 1);
    checkOutput("stall_lc_valid_before", lc_valid, 0);
    forceBusy = 1'b0;
    @(negedge clk);
    checkOutput("stall_lc_valid_after", lc_valid, 1);
    checkOutput("stall_addr_lane0", laneOf(lc_st_addr, 0), 10);
    waitFrameEnd(200, "stall");
    checkOutput("stall_strobes", strobeCount - sBase, 1);
    checkOutput("stall_done", doneCount - dBase, 1);

    $display("[TB] lane wrap");
    sBase = strobeCount;
    applyStimulus({13'd30, 13'd20, 13'd10, 13'd8190}, 13'd4, 10'd2, 10'd5, 1'b0, 1'b1, 1'b0);
    waitFrameEnd(200, "wrap");
    checkOutput("wrap_strobes", strobeCount - sBase, 2);
    checkOutput("wrap_first_lane0", laneOf(addrLog[sBase], 0), 8190);
    checkOutput("wrap_second_lane0", laneOf(addrLog[sBase+1], 0), 2);
    checkOutput("wrap_second_lane1", laneOf(addrLog[sBase+1], 1), 14);
    checkOutput("wrap_second_lane3", laneOf(addrLog[sBase+1], 3), 34);
    checkOutput("wrap_tofifo_held", lc_tofifo, 1);
    checkOutput("wrap_linelen_held", lc_linelen, 5);

    $display("[TB] abort after second line");
    sBase = strobeCount; dBase = doneCount;
    applyStimulus({13'd400, 13'd300, 13'd200, 13'd100}, 13'd8, 10'd4, 10'd3, 1'b0, 1'b0, 1'b0);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (lc_valid) seen = seen + 1;
      if (seen == 2) break;
      @(negedge clk);
    end
    checkOutput("abort_second_seen", seen, 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_ready", cfg_ready, 1);
    repeat (20) @(negedge clk);
    #1;
    checkOutput("abort_strobes", strobeCount - sBase, 2);
    checkOutput("abort_no_done", doneCount - dBase, 0);
    checkOutput("abort_lines_issued", lines_issued, 2);

    $display("[TB] reset mid-frame");
    applyStimulus({13'd53, 13'd52, 13'd51, 13'd50}, 13'd2, 10'd3, 10'd7, 1'b1, 1'b1, 1'b1);
    seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (lc_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    checkOutput("rstmid_first_seen", seen, 1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid_lc_valid", lc_valid, 0);
    checkOutput("rstmid_st_addr", lc_st_addr, 0);
    checkOutput("rstmid_linelen", lc_linelen, 0);
    checkOutput("rstmid_flags", {lc_ispad, lc_tofifo, lc_fromfifo}, 0);
    checkOutput("rstmid_done", done, 0);
    checkOutput("rstmid_busy", busy, 0);
    checkOutput("rstmid_ready", cfg_ready, 1);
    checkOutput("rstmid_lines_issued", lines_issued, 0);
    sBase = strobeCount; dBase = doneCount;
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    checkOutput("rstmid_quiet_strobes", strobeCount - sBase, 0);
    checkOutput("rstmid_quiet_done", doneCount - dBase, 0);
    applyStimulus({13'd4000, 13'd3000, 13'd2000, 13'd1000}, 13'd1, 10'd2, 10'd9, 1'b0, 1'b0, 1'b1);
    waitFrameEnd(200, "rstnew");
    checkOutput("rstnew_strobes", strobeCount - sBase, 2);
    checkOutput("rstnew_first_lane0", laneOf(addrLog[sBase], 0), 1000);
    checkOutput("rstnew_first_lane3", laneOf(addrLog[sBase], 3), 4000);
    checkOutput("rstnew_second_lane0", laneOf(addrLog[sBase+1], 0), 1001);
    checkOutput("rstnew_done", doneCount - dBase, 1);
    checkOutput("rstnew_lines_issued", lines_issued, 2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
